dmem_lsu: RTL and testbench

Load/store initiator that drives the byte-addressed data memory port from the pipeline's memory stage.
- Accepts one request per cycle via valid/ready.
- Generates the 4-bit byte-lane write mask and lane-aligned write data.
- Formats load data: byte/half/word, signed or zero extended.
- Implements an atomic SWAP as a two-cycle read-then-write sequence.
- Returns every result, including store acks, on a valid/ready response channel.

---
 rtl/dmem_lsu.sv | 101 ++++++++++
 tb/tb_dmem_lsu.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator for a byte-lane data memory, with two-cycle atomic swap.
// Ports: clk/rst (sync, active high); req_* valid/ready request channel (op, size, signed,
// addr, wdata); resp_* valid/ready response channel (rdata, err); dmem_* memory port
// (we lane mask, addr, wdata out; rdata in, sampled one rising edge after issue).
// Optional: define DMEM_LSU_ALIGN_CHECK_EN to reject misaligned half/word accesses with resp_err_o.
module dmem_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [1:0]              req_op_i,
    input  logic [1:0]              req_size_i,
    input  logic                    req_signed_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                    resp_err_o,
    output logic [DATA_WIDTH/8-1:0] dmem_we_o,
    output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
    output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata_i
);
    localparam int LANES = DATA_WIDTH / 8;
    typedef enum logic {IDLE, SWAP_WR} state_t;
    state_t                r_state;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LANES-1:0]      r_mask;
    logic                  w_fire;
    logic                  w_misaligned;
    logic                  w_err;
    logic                  w_swap;
    logic [LANES-1:0]      w_mask;
    logic [DATA_WIDTH-1:0] w_ld;

    function automatic logic [DATA_WIDTH-1:0] fmt(input logic [DATA_WIDTH-1:0] d,
                                                  input logic [1:0] sz, input logic sg);
        return sz == 2'b00 ? {{(DATA_WIDTH-8){sg & d[7]}}, d[7:0]} :
               sz == 2'b01 ? {{(DATA_WIDTH-16){sg & d[15]}}, d[15:0]} : d;
    endfunction

    assign req_ready_o = (r_state == IDLE) && !rst && (!r_resp_valid || resp_ready_i);
    assign w_fire      = req_valid_i && req_ready_o;
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    assign w_misaligned = (req_size_i == 2'b01 && req_addr_i[0]) ||
                          (req_size_i[1] && req_addr_i[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif
    assign w_err  = (req_op_i == 2'b11) || w_misaligned;
    assign w_swap = (req_op_i == 2'b10) && !w_err;
    assign w_mask = req_size_i == 2'b00 ? LANES'(1) : req_size_i == 2'b01 ? LANES'(3) : '1;
    // Inputs of the issue cycle and the memory's falling-edge read data are both
    // still valid at the rising edge that ends the issue cycle, so formatting happens here.
    assign w_ld = fmt(dmem_rdata_i, req_size_i, req_signed_i);

    // Reset gates the swap write phase so an aborted swap leaves memory untouched.
    assign dmem_we_o    = rst ? '0 :
                          r_state == SWAP_WR ? r_mask :
                          (w_fire && req_op_i == 2'b01 && !w_err) ? w_mask : '0;
    assign dmem_addr_o  = r_state == SWAP_WR ? r_addr : req_addr_i;
    assign dmem_wdata_o = r_state == SWAP_WR ? r_wdata : req_wdata_i;

    assign resp_valid_o = r_resp_valid;
    assign resp_rdata_o = r_resp_rdata;
    assign resp_err_o   = r_resp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else if (r_state == SWAP_WR) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_hold;
            r_resp_err   <= 1'b0;
        end else if (w_fire) begin
            r_state      <= w_swap ? SWAP_WR : IDLE;
            r_resp_valid <= !w_swap;
            r_resp_rdata <= (req_op_i == 2'b00 && !w_err) ? w_ld : '0;
            r_resp_err   <= w_err;
            r_hold       <= w_ld;
            r_addr       <= req_addr_i;
            r_wdata      <= req_wdata_i;
            r_mask       <= w_mask;
        end else if (resp_ready_i) begin
            r_resp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized and directed bench for dmem_lsu against a request-level memory model.
module tb_dmem_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_op_i = 2'b00;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_signed_i = 1'b0;
    logic [15:0] req_addr_i = 16'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic [3:0]  dmem_we_o;
    logic [15:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i = 32'h0;

    logic [7:0]  mem    [0:65535];
    logic [7:0]  shadow [0:65535];
    logic [31:0] exp_d[$];
    logic        exp_e[$];
    int          total = 0;
    int          bad = 0;
    int          n_hs = 0;
    logic        p_stall = 1'b0;
    logic [31:0] p_d = 32'h0;
    logic        p_e = 1'b0;
    logic        rnd_on = 1'b0;

    dmem_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rdata_i(dmem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, got, want);
        end
    endtask

    // Request-level reference: each accepted request acts on the shadow byte array at once.
    task automatic model(input logic [1:0] op, input logic [1:0] sz, input logic sg,
                         input logic [15:0] a, input logic [31:0] wd);
        int n;
        logic [31:0] v;
        logic er;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        er = (op == 2'd3);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        if ((int'(a) % n) != 0) er = 1'b1;
`endif
        v = 32'h0;
        if (!er && op != 2'd1) begin
            for (int k = 0; k < n; k++) v |= 32'(shadow[16'(int'(a) + k)]) << (8 * k);
            if (sg && n < 4 && v[8*n-1]) v |= 32'hFFFFFFFF << (8 * n);
        end
        if (!er && op != 2'd0)
            for (int k = 0; k < n; k++) shadow[16'(int'(a) + k)] = wd[8*k +: 8];
        exp_d.push_back(v);
        exp_e.push_back(er);
    endtask

    // Memory: writes lanes then presents read data on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++)
            if (dmem_we_o[k]) mem[16'(int'(dmem_addr_o) + k)] = dmem_wdata_o[8*k +: 8];
        for (int k = 0; k < 4; k++)
            dmem_rdata_i[8*k +: 8] <= mem[16'(int'(dmem_addr_o) + k)];
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_we", 32'(dmem_we_o), 32'h0);
        end else begin
            if (p_stall) begin
                chk("hold_valid", 32'(resp_valid_o), 32'h1);
                chk("hold_data", resp_rdata_o, p_d);
                chk("hold_err", 32'(resp_err_o), 32'(p_e));
            end
            if (resp_valid_o && !resp_ready_i) begin
                chk("stall_ready", 32'(req_ready_o), 32'h0);
                chk("stall_we", 32'(dmem_we_o), 32'h0);
            end
            if (resp_valid_o && resp_ready_i) begin
                n_hs++;
                if (exp_d.size() == 0) chk("resp_expected", 32'(exp_d.size() != 0), 32'h1);
                else begin
                    chk("resp_data", resp_rdata_o, exp_d.pop_front());
                    chk("resp_err", 32'(resp_err_o), 32'(exp_e.pop_front()));
                end
            end
            if (req_valid_i && req_ready_o)
                model(req_op_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i);
        end
        p_stall = !rst && resp_valid_o && !resp_ready_i;
        p_d = resp_rdata_o;
        p_e = resp_err_o;
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present a request from posedge+1 until it is accepted; returns at posedge+1 after the fire cycle.
    task automatic send(input logic [1:0] op, input logic [1:0] sz, input logic sg,
                        input logic [15:0] a, input logic [31:0] wd, output logic [3:0] fwe);
        logic done;
        done = 1'b0;
        fwe = 4'h0;
        req_valid_i = 1'b1;
        req_op_i = op;
        req_size_i = sz;
        req_signed_i = sg;
        req_addr_i = a;
        req_wdata_i = wd;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = req_ready_o;
            fwe = dmem_we_o;
            sync();
        end
        req_valid_i = 1'b0;
        chk("send_fire", 32'(done), 32'h1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] fwe;
        int hs0;
        int r;
        int nbad_mem;
        logic [1:0] op;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
        end
        {mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]} = 32'hCAFEF00D;
        {shadow[16'h23], shadow[16'h22], shadow[16'h21], shadow[16'h20]} = 32'hCAFEF00D;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(resp_valid_o), 32'h0);
        chk("rst_rdata", resp_rdata_o, 32'h0);
        chk("rst_err", 32'(resp_err_o), 32'h0);
        chk("rst_ready", 32'(req_ready_o), 32'h0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready_o), 32'h1);

        sync();
        send(2'd1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, fwe);
        chk("st_we", 32'(fwe), 32'hF);
        @(negedge clk);
        chk("st_ack_valid", 32'(resp_valid_o), 32'h1);
        chk("st_ack_rdata", resp_rdata_o, 32'h0);
        chk("st_we_once", 32'(dmem_we_o), 32'h0);
        sync();
        send(2'd0, 2'd2, 1'b0, 16'h0010, 32'h0, fwe);
        chk("ld_we", 32'(fwe), 32'h0);
        @(negedge clk);
        chk("ld_lat1", 32'(resp_valid_o), 32'h1);
        chk("ld_word", resp_rdata_o, 32'hDEADBEEF);
        chk("ld_err", 32'(resp_err_o), 32'h0);
        sync();
        send(2'd0, 2'd0, 1'b1, 16'h0011, 32'h0, fwe);
        @(negedge clk);
        chk("ld_sbyte", resp_rdata_o, 32'hFFFFFFBE);
        sync();
        send(2'd0, 2'd0, 1'b0, 16'h0011, 32'h0, fwe);
        @(negedge clk);
        chk("ld_ubyte", resp_rdata_o, 32'h000000BE);
        sync();
        send(2'd0, 2'd1, 1'b1, 16'h0012, 32'h0, fwe);
        @(negedge clk);
        chk("ld_shalf", resp_rdata_o, 32'hFFFFDEAD);

        sync();
        send(2'd2, 2'd2, 1'b0, 16'h0010, 32'h12345678, fwe);
        chk("swp_rd_we", 32'(fwe), 32'h0);
        @(negedge clk);
        chk("swp_ready", 32'(req_ready_o), 32'h0);
        chk("swp_we", 32'(dmem_we_o), 32'hF);
        chk("swp_addr", 32'(dmem_addr_o), 32'h10);
        chk("swp_wdata", dmem_wdata_o, 32'h12345678);
        chk("swp_no_early", 32'(resp_valid_o), 32'h0);
        sync();
        @(negedge clk);
        chk("swp_lat2", 32'(resp_valid_o), 32'h1);
        chk("swp_old", resp_rdata_o, 32'hDEADBEEF);
        chk("swp_we_once", 32'(dmem_we_o), 32'h0);
        sync();
        send(2'd0, 2'd2, 1'b0, 16'h0010, 32'h0, fwe);
        @(negedge clk);
        chk("swp_new", resp_rdata_o, 32'h12345678);

        sync();
        hs0 = n_hs;
        fork
            begin
                send(2'd0, 2'd2, 1'b0, 16'h0010, 32'h0, fwe);
                send(2'd0, 2'd2, 1'b0, 16'h0020, 32'h0, fwe);
                send(2'd0, 2'd2, 1'b0, 16'h0000, 32'h0, fwe);
            end
            begin
                for (int i = 0; i < 50 && !resp_valid_o; i++) @(negedge clk);
                sync();
                resp_ready_i = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bb_stall_valid", 32'(resp_valid_o), 32'h1);
                    chk("bb_stall_ready", 32'(req_ready_o), 32'h0);
                end
                sync();
                resp_ready_i = 1'b1;
            end
        join
        repeat (4) sync();
        chk("bb_count", 32'(n_hs - hs0), 32'd3);

        send(2'd2, 2'd2, 1'b0, 16'h0020, 32'h11111111, fwe);
        rst = 1'b1;
        exp_d.delete();
        exp_e.delete();
        {shadow[16'h23], shadow[16'h22], shadow[16'h21], shadow[16'h20]} = 32'hCAFEF00D;
        @(negedge clk);
        chk("rst_swp_we", 32'(dmem_we_o), 32'h0);
        chk("rst_swp_valid", 32'(resp_valid_o), 32'h0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_swp_noresp", 32'(resp_valid_o), 32'h0);
        sync();
        send(2'd0, 2'd2, 1'b0, 16'h0020, 32'h0, fwe);
        @(negedge clk);
        chk("rst_swp_mem", resp_rdata_o, 32'hCAFEF00D);

        sync();
        send(2'd0, 2'd2, 1'b0, 16'h0011, 32'h0, fwe);
        @(negedge clk);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        chk("mis_ld_err", 32'(resp_err_o), 32'h1);
        chk("mis_ld_rdata", resp_rdata_o, 32'h0);
`else
        chk("mis_ld_err", 32'(resp_err_o), 32'h0);
        chk("mis_ld_rdata", resp_rdata_o, 32'h4E123456);
`endif
        sync();
        send(2'd1, 2'd2, 1'b0, 16'h0022, 32'hA5A5C3C3, fwe);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        chk("mis_st_we", 32'(fwe), 32'h0);
`else
        chk("mis_st_we", 32'(fwe), 32'hF);
`endif
        send(2'd2, 2'd1, 1'b1, 16'h0013, 32'h0000ABCD, fwe);
        @(negedge clk);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        chk("mis_swp_valid", 32'(resp_valid_o), 32'h1);
        chk("mis_swp_err", 32'(resp_err_o), 32'h1);
        chk("mis_swp_we", 32'(dmem_we_o), 32'h0);
`else
        chk("mis_swp_valid", 32'(resp_valid_o), 32'h0);
        chk("mis_swp_we", 32'(dmem_we_o), 32'h3);
        chk("mis_swp_ready", 32'(req_ready_o), 32'h0);
`endif
        sync();
        send(2'd3, 2'd2, 1'b0, 16'h0010, 32'hFFFFFFFF, fwe);
        chk("rsv_we", 32'(fwe), 32'h0);
        @(negedge clk);
        chk("rsv_err", 32'(resp_err_o), 32'h1);
        chk("rsv_rdata", resp_rdata_o, 32'h0);

        sync();
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    sync();
                    resp_ready_i = ($urandom_range(0, 3) != 0);
                end
                resp_ready_i = 1'b1;
            end
            begin
                for (int n = 0; n < 400; n++) begin
                    if ($urandom_range(0, 3) == 0) sync();
                    r = $urandom_range(0, 9);
                    op = r < 4 ? 2'd0 : r < 7 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
                    send(op, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         16'($urandom_range(0, 63)), $urandom, fwe);
                end
                rnd_on = 1'b0;
            end
        join
        resp_ready_i = 1'b1;
        repeat (6) sync();
        chk("drain", 32'(exp_d.size()), 32'h0);
        nbad_mem = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== shadow[i]) nbad_mem++;
        chk("mem_image", 32'(nbad_mem), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
